// File: rtl/cnn_mul_arb_pkg.sv
// Shared widths, helper function and the beat record for the shared-multiplier arbiter.
package cnn_mul_arb_pkg;

  localparam int A_W      = 8;
  localparam int B_W      = 14;
  localparam int P_W      = A_W + B_W;
  localparam int ACC_W    = 32;
  localparam int ID_MAX_W = 3;    // enough for up to 8 lanes

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  typedef struct packed {
    logic [ID_MAX_W-1:0]   id;
    logic                  last;
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
  } beat_t;

endpackage

// File: rtl/cnn_mul_pipe_tagged.sv
// LAT-stage signed multiplier; the lane tag and last flag ride alongside the product.
module cnn_mul_pipe_tagged
  import cnn_mul_arb_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_vld,
  input  beat_t                 in_beat,
  output logic                  out_vld,
  output logic [ID_MAX_W-1:0]   out_id,
  output logic                  out_last,
  output logic signed [P_W-1:0] out_prod,
  output logic                  busy
);

  logic [LAT:1]          vld_pipe;
  logic [LAT:1]          r_last;
  logic [ID_MAX_W-1:0]   r_id   [1:LAT];
  logic signed [P_W-1:0] r_prod [1:LAT];
  logic signed [P_W-1:0] w_a_ext, w_b_ext;

  assign w_a_ext = P_W'($signed(in_beat.a));
  assign w_b_ext = P_W'($signed(in_beat.b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[1] <= in_vld;
      for (int s = 2; s <= LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  // Payload needs no reset: it is qualified by vld_pipe everywhere.
  always_ff @(posedge clk) begin
    if (en) begin
      r_prod[1] <= w_a_ext * w_b_ext;
      r_id[1]   <= in_beat.id;
      r_last[1] <= in_beat.last;
      for (int s = 2; s <= LAT; s++) begin
        r_prod[s] <= r_prod[s-1];
        r_id[s]   <= r_id[s-1];
        r_last[s] <= r_last[s-1];
      end
    end
  end

  assign out_vld  = vld_pipe[LAT];
  assign out_id   = r_id[LAT];
  assign out_last = r_last[LAT];
  assign out_prod = r_prod[LAT];
  assign busy     = |vld_pipe;

endmodule

// File: rtl/cnn_mul_share_arb.sv
// Round-robin sharing of one pipelined multiplier among NREQ lanes, with per-lane
// accumulators and a single held result register.
module cnn_mul_share_arb #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int ACC_W = cnn_mul_arb_pkg::ACC_W,
  localparam int ID_W = cnn_mul_arb_pkg::clog2(NREQ)
) (
  input  logic                                ap_clk,
  input  logic                                ap_rst_n,
  input  logic [NREQ-1:0]                     req_valid,
  output logic [NREQ-1:0]                     req_ready,
  input  logic [NREQ*cnn_mul_arb_pkg::A_W-1:0] req_a,
  input  logic [NREQ*cnn_mul_arb_pkg::B_W-1:0] req_b,
  input  logic [NREQ-1:0]                     req_last,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [ID_W-1:0]                     res_id,
  output logic [ACC_W-1:0]                    res_data,
  output logic                                busy
);
  import cnn_mul_arb_pkg::*;

  logic                    w_stall;
  logic [ID_W-1:0]         r_ptr, w_gnt;
  logic                    w_gnt_vld;
  logic [2*NREQ-1:0]       w_rot;
  beat_t                   w_beat;
  logic                    w_out_vld, w_out_last, w_exit, w_pipe_busy;
  logic [ID_MAX_W-1:0]     w_out_id;
  logic signed [P_W-1:0]   w_out_prod;
  logic [ACC_W-1:0]        r_acc [NREQ];
  logic [ACC_W-1:0]        w_acc_sel, w_sum;
  logic                    r_res_valid;
  logic [ID_W-1:0]         r_res_id;
  logic [ACC_W-1:0]        r_res_data;

  assign w_stall = r_res_valid & ~res_ready;

  // Rotate so bit 0 is the lane at the pointer; first set bit is the winner.
  assign w_rot = {req_valid, req_valid} >> r_ptr;

  always_comb begin
    int g;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    g         = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_vld && w_rot[k]) begin
        w_gnt_vld = 1'b1;
        g = int'(r_ptr) + k;
        if (g >= NREQ) g = g - NREQ;
        w_gnt = ID_W'(g);
      end
    end
    if (w_stall) w_gnt_vld = 1'b0;
  end

  always_comb begin
    req_ready   = '0;
    w_beat      = '0;
    w_beat.id   = ID_MAX_W'(w_gnt);
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == ID_W'(i)) begin
        req_ready[i] = w_gnt_vld;
        w_beat.last  = req_last[i];
        w_beat.a     = req_a[i*A_W +: A_W];
        w_beat.b     = req_b[i*B_W +: B_W];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)
      r_ptr <= '0;
    else if (w_gnt_vld)
      r_ptr <= (w_gnt == ID_W'(NREQ-1)) ? '0 : w_gnt + 1'b1;
  end

  cnn_mul_pipe_tagged #(.LAT(LAT)) u_pipe (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .en       (~w_stall),
    .in_vld   (w_gnt_vld),
    .in_beat  (w_beat),
    .out_vld  (w_out_vld),
    .out_id   (w_out_id),
    .out_last (w_out_last),
    .out_prod (w_out_prod),
    .busy     (w_pipe_busy)
  );

  assign w_exit = w_out_vld & ~w_stall;

  always_comb begin
    w_acc_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_out_id == ID_MAX_W'(i)) w_acc_sel = r_acc[i];
  end

  // Sign-extend the product and wrap modulo 2^ACC_W.
  assign w_sum = w_acc_sel + ACC_W'(w_out_prod);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NREQ; i++) r_acc[i] <= '0;
    end else if (w_exit) begin
      for (int i = 0; i < NREQ; i++)
        if (w_out_id == ID_MAX_W'(i)) r_acc[i] <= w_out_last ? '0 : w_sum;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
    end else if (!w_stall) begin
      if (w_exit && w_out_last) begin
        r_res_valid <= 1'b1;
        r_res_id    <= w_out_id[ID_W-1:0];
        r_res_data  <= w_sum;
      end else if (res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_data  = r_res_data;
  assign busy      = w_pipe_busy | r_res_valid;

endmodule

// File: doc/cnn_mul_share_arb.md
Name: cnn_mul_share_arb

Overview:
Time-shares one pipelined signed 8x14 multiplier among NREQ convolution lanes using round-robin arbitration. Each lane streams (activation, weight) beats with a last flag. The block accumulates each lane's products in a private accumulator. On the lane's last beat it emits the tagged dot-product result. It sits between the lane feeders and the per-channel bias/activation stage of the CNN core.

Parameters:
NREQ, 4, number of requesting lanes (2..8)
A_W, 8, signed activation width
B_W, 14, signed weight width
P_W, 22, product width (A_W+B_W)
LAT, 2, multiplier pipeline stages (1..4)
ACC_W, 32, accumulator/result width (>= P_W)
ID_W, clog2(NREQ), lane tag width

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-lane beat valid
req_ready  out  NREQ  per-lane accept (one-hot or zero)
req_a  in  NREQ*A_W  packed signed activations, lane i at [i*A_W +: A_W]
req_b  in  NREQ*B_W  packed signed weights, lane i at [i*B_W +: B_W]
req_last  in  NREQ  last beat of lane's dot product
res_valid  out  1  result valid
res_ready  in  1  downstream accept
res_id  out  ID_W  lane of result
res_data  out  ACC_W  signed accumulated result
busy  out  1  any pipeline stage valid or res_valid high

Behaviour:
- Reset (async assert, sync deassert in the clock domain):
  - res_valid=0, res_id=0, res_data=0, busy=0.
  - All pipeline valid bits=0, all accumulators=0, RR pointer=0.
- stall = res_valid & ~res_ready. While stalled:
  - req_ready=0.
  - Pipeline and accumulators hold their state.
- Grant:
  - When not stalled, grant the first valid lane scanning from pointer upward, with modulo-NREQ wrap.
  - req_ready[g]=1 combinationally. The handshake is req_valid & req_ready.
  - After a grant to g, pointer = (g+1) mod NREQ. With no grant, the pointer is unchanged.
- Pipeline: an accepted beat enters stage 1 carrying {id, last, a, b}. The product is a full-precision signed a*b (P_W bits) and is valid at stage LAT.
- Stage-LAT exit (not stalled) for lane id:
  - Compute sum = acc[id] + sign-extended product, modulo 2^ACC_W (wraps, no saturation).
  - If last=0: acc[id] <= sum.
  - If last=1: res_data <= sum, res_id <= id, res_valid <= 1, acc[id] <= 0.
- Latency: a last beat accepted at edge E raises res_valid after edge E+LAT, absent stalls. Throughput is 1 beat/cycle aggregate.
- Result hold: res_valid/res_id/res_data are stable until res_ready=1.
  - If res_ready=1 and a new last exits in the same cycle, load the new result back-to-back.
  - Otherwise clear res_valid on res_ready.
- Simultaneous events:
  - A grant and a stage-LAT exit for the same lane in one cycle are independent. The accumulator is touched only at exit.
  - A lane may have up to LAT beats in flight.
- Protocol rule: req_a, req_b and req_last must be stable while req_valid=1 and not accepted. req_valid must not wait for req_ready.
- Reset mid-operation discards in-flight beats and partial sums. No result is emitted for them.

Decomposition:
- Package cnn_mul_arb_pkg holds:
  - Width constants A_W, B_W, P_W, ACC_W.
  - A clog2 function.
  - A beat struct {id, last, a, b}.
- Sub-module cnn_mul_pipe_tagged: LAT-stage signed multiplier with an enable (~stall) that carries the id/last tag alongside the product.
- The top level holds the RR arbiter, accumulator bank and result register.

Test Plan:
- Lane 0 only, beats (1,1),(-128,8191),(2,3, last) with res_ready=1 -> one result, res_id=0, res_data=-1048441, res_valid after edge E+LAT of the last beat.
- All 4 lanes valid continuously, each sending 2 beats (1,1),(1,1,last) -> grant order 0,1,2,3,0,1,2,3; results id 0..3, each res_data=2, appearing on consecutive cycles.
- Extremes: lane 2 sends (-128,-8192,last) -> res_data=1048576. Lane 1 sends (127,-8192,last) -> res_data=-1040384.
- Backpressure: hold res_ready=0 for 5 cycles while results are pending -> req_ready=0 throughout, and res_data/res_id stay stable. On release, no result is lost or duplicated and grant order resumes from the saved pointer.
- Wrap with ACC_W=22: lane 0 sends (-128,-8192),(-128,-8192,last) -> res_data=-2097152 (two's-complement wrap).
- Reset mid-operation: drop ap_rst_n after 2 non-last beats on lane 3 -> outputs reset immediately. After release, a (5,7,last) beat on lane 3 yields res_data=35 (no stale partial sum).
